fetch_unit: RTL and testbench

- Parametrised N-wide instruction fetch stage.
- Generates the PC and issues aligned bundle requests to instruction memory, with at most one outstanding request.
- Buffers returned instructions in a FIFO queue and presents up to FETCH_WIDTH instructions per cycle, with their PCs, to decode.
- Handles redirects and end-of-program. Sits between instruction memory and the rename/decode stage of the superscalar core.

---
 rtl/fetch_unit.sv | 103 ++++++++++
 tb/tb_fetch_unit.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// fetch_unit: N-wide fetch stage; PC gen + one-outstanding imem bundle requests (imem_*), FIFO of instr/PC to decode (instr_*, deq_i, count_o), redirect flush, done_o; define FETCH_UNIT_STATS_EN for stall_cycles_o/killed_bundles_o
module fetch_unit #(
  parameter int PC_SIZE = 32,
  parameter int INSTR_SIZE = 32,
  parameter int FETCH_WIDTH = 2,
  parameter int QUEUE_DEPTH = 8,
  parameter logic [PC_SIZE-1:0] RESET_PC = '0
) (
  input  logic                                  clk_i,
  input  logic                                  rst_ni,
  output logic                                  imem_req_o,
  output logic [PC_SIZE-1:0]                    imem_addr_o,
  input  logic                                  imem_ready_i,
  input  logic                                  imem_rvalid_i,
  input  logic [FETCH_WIDTH*INSTR_SIZE-1:0]     imem_rdata_i,
  input  logic                                  imem_rdone_i,
  input  logic                                  redirect_i,
  input  logic [PC_SIZE-1:0]                    redirect_pc_i,
  output logic [FETCH_WIDTH-1:0]                instr_valid_o,
  output logic [FETCH_WIDTH*INSTR_SIZE-1:0]     instr_o,
  output logic [FETCH_WIDTH*PC_SIZE-1:0]        instr_pc_o,
  input  logic [$clog2(FETCH_WIDTH+1)-1:0]      deq_i,
  output logic [$clog2(QUEUE_DEPTH+1)-1:0]      count_o,
  output logic                                  done_o
`ifdef FETCH_UNIT_STATS_EN
  ,
  output logic [31:0]                           stall_cycles_o,
  output logic [31:0]                           killed_bundles_o
`endif
);
  localparam int PW = $clog2(QUEUE_DEPTH);
  localparam int CW = $clog2(QUEUE_DEPTH+1);
  localparam int OW = FETCH_WIDTH > 1 ? $clog2(FETCH_WIDTH) : 1;
  localparam logic [PC_SIZE-1:0] BUNDLE_BYTES = PC_SIZE'(FETCH_WIDTH*4);
  typedef enum logic [2:0] {IDLE, FETCH, WAIT, KILL, DONE} state_t;
  state_t state, state_d;
  logic [PC_SIZE-1:0] pc;
  logic [OW-1:0] offset;
  logic [CW-1:0] count, enq_n, deq_n;
  logic [PW-1:0] head, tail;
  logic [INSTR_SIZE-1:0] q_instr [QUEUE_DEPTH];
  logic [PC_SIZE-1:0] q_pc [QUEUE_DEPTH];
  logic req_fire, enq;
  assign imem_req_o = state == FETCH && (CW'(QUEUE_DEPTH) - count) >= CW'(FETCH_WIDTH);
  assign imem_addr_o = pc;
  assign req_fire = imem_req_o && imem_ready_i;
  assign enq = state == WAIT && imem_rvalid_i && !imem_rdone_i && !redirect_i;
  assign enq_n = enq ? CW'(FETCH_WIDTH) - CW'(offset) : '0;
  assign deq_n = redirect_i ? '0 : (CW'(deq_i) > count ? count : CW'(deq_i));
  assign count_o = count;
  assign done_o = state == DONE && count == '0;
  always_comb begin
    state_d = state;
    case (state)
      IDLE:  state_d = FETCH;
      FETCH: state_d = req_fire ? (redirect_i ? KILL : WAIT) : FETCH;
      WAIT:  state_d = redirect_i ? (imem_rvalid_i ? FETCH : KILL) :
                       !imem_rvalid_i ? WAIT : imem_rdone_i ? DONE : FETCH;
      KILL:  state_d = imem_rvalid_i ? FETCH : KILL;
      DONE:  state_d = redirect_i ? FETCH : DONE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) begin
      state <= IDLE;
      pc <= RESET_PC;
      offset <= '0;
      count <= '0;
      head <= '0;
      tail <= '0;
    end else begin
      state <= state_d;
      count <= redirect_i ? '0 : count + enq_n - deq_n;
      head <= redirect_i ? '0 : head + PW'(deq_n);
      tail <= redirect_i ? '0 : tail + PW'(enq_n);
      pc <= redirect_i ? redirect_pc_i & ~(BUNDLE_BYTES - 1'b1) : req_fire ? pc + BUNDLE_BYTES : pc;
      offset <= redirect_i ? (FETCH_WIDTH > 1 ? redirect_pc_i[OW+1:2] : '0) : enq ? '0 : offset;
    end
  always_ff @(posedge clk_i)
    for (int k = 0; k < FETCH_WIDTH; k++)
      if (enq && k >= int'(offset)) begin
        q_instr[tail + PW'(k) - PW'(offset)] <= imem_rdata_i[k*INSTR_SIZE +: INSTR_SIZE];
        q_pc[tail + PW'(k) - PW'(offset)] <= pc - BUNDLE_BYTES + PC_SIZE'(4*k);
      end
  for (genvar i = 0; i < FETCH_WIDTH; i++) begin : g_out
    assign instr_valid_o[i] = count > CW'(i);
    assign instr_o[i*INSTR_SIZE +: INSTR_SIZE] = q_instr[head + PW'(i)];
    assign instr_pc_o[i*PC_SIZE +: PC_SIZE] = q_pc[head + PW'(i)];
  end
`ifdef FETCH_UNIT_STATS_EN
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) begin
      stall_cycles_o <= '0;
      killed_bundles_o <= '0;
    end else begin
      if (state == FETCH && !imem_req_o && stall_cycles_o != '1)
        stall_cycles_o <= stall_cycles_o + 1'b1;
      if (imem_rvalid_i && (state == KILL || (redirect_i && state == WAIT)) && killed_bundles_o != '1)
        killed_bundles_o <= killed_bundles_o + 1'b1;
    end
`endif
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed + random bench for fetch_unit against a queue-level reference model
module tb_fetch_unit;
  localparam int FW = 2;
  localparam int QD = 8;
  typedef struct {logic [31:0] pc; logic [31:0] ins;} ent_t;
  logic clk = 0, rst_n = 0;
  logic req, ready, rvalid, rdone, redir, done;
  logic [31:0] addr, rpc;
  logic [63:0] rdata, instr, ipc;
  logic [1:0] valid, deq;
  logic [3:0] count;
`ifdef FETCH_UNIT_STATS_EN
  logic [31:0] stall, killed;
`endif
  ent_t q[$];
  logic [31:0] m_pc, out_addr, prog_end, m_stall, m_killed;
  bit m_off, outstanding, killed_f, ended, started;
  int lat, lat_lo, lat_hi, checks, errors;
  always #5 clk = ~clk;
  fetch_unit #(.PC_SIZE(32), .INSTR_SIZE(32), .FETCH_WIDTH(FW), .QUEUE_DEPTH(QD), .RESET_PC(32'h0)) dut (
    .clk_i(clk), .rst_ni(rst_n), .imem_req_o(req), .imem_addr_o(addr), .imem_ready_i(ready),
    .imem_rvalid_i(rvalid), .imem_rdata_i(rdata), .imem_rdone_i(rdone), .redirect_i(redir),
    .redirect_pc_i(rpc), .instr_valid_o(valid), .instr_o(instr), .instr_pc_o(ipc), .deq_i(deq),
    .count_o(count), .done_o(done)
`ifdef FETCH_UNIT_STATS_EN
    , .stall_cycles_o(stall), .killed_bundles_o(killed)
`endif
  );
  function automatic logic [31:0] word(input logic [31:0] a);
    return {a[15:0] ^ 16'h5A3C, ~a[15:0]};
  endfunction
  function automatic bit exp_req();
    return started && !outstanding && !ended && (QD - q.size() >= FW);
  endfunction
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask
  task automatic check_all();
    chk("req", req, exp_req());
    chk("addr", addr, m_pc);
    chk("count", count, q.size());
    chk("done", done, ended && q.size() == 0);
    for (int k = 0; k < FW; k++) begin
      chk("valid", valid[k], q.size() > k);
      if (q.size() > k) begin
        chk("ipc", ipc[k*32 +: 32], q[k].pc);
        chk("instr", instr[k*32 +: 32], q[k].ins);
      end
    end
`ifdef FETCH_UNIT_STATS_EN
    chk("stall", stall, m_stall);
    chk("killed", killed, m_killed);
`endif
  endtask
  task automatic reset_dut();
    rst_n = 0;
    #1;
    chk("rst_req", req, 0);
    chk("rst_valid", valid, 0);
    chk("rst_count", count, 0);
    chk("rst_done", done, 0);
    chk("rst_addr", addr, 0);
    q.delete();
    m_pc = 0; m_off = 0; outstanding = 0; killed_f = 0; ended = 0; started = 0;
    m_stall = 0; m_killed = 0; lat = 0;
    ready = 0; deq = 0; redir = 0; rpc = 0; rvalid = 0; rdone = 0; rdata = 0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1;
    check_all();
  endtask
  task automatic step(input bit rdy, input logic [1:0] d, input bit rd_in, input logic [31:0] rp);
    bit rv, rdn, acc;
    int n;
    ent_t e;
    rv = 0;
    if (outstanding) begin
      if (lat == 0) rv = 1;
      else lat--;
    end
    rdn = rv && out_addr >= prog_end;
    ready = rdy; deq = d; redir = rd_in; rpc = rp;
    rvalid = rv; rdone = rdn; rdata = rv ? {word(out_addr + 4), word(out_addr)} : '0;
    acc = exp_req() && rdy;
    if (started && !outstanding && !ended && !exp_req()) m_stall++;
    if (rv && (killed_f || rd_in)) m_killed++;
    @(posedge clk);
    if (rd_in) begin
      q.delete();
      if (rv) begin outstanding = 0; killed_f = 0; end
      else if (outstanding) killed_f = 1;
      if (acc) begin
        outstanding = 1; killed_f = 1; out_addr = m_pc;
        lat = lat_lo + int'($urandom_range(0, lat_hi - lat_lo));
      end
      m_pc = rp & ~32'h7; m_off = rp[2]; ended = 0;
    end else begin
      n = (d > q.size()) ? q.size() : int'(d);
      repeat (n) void'(q.pop_front());
      if (rv) begin
        outstanding = 0;
        if (killed_f) killed_f = 0;
        else if (rdn) ended = 1;
        else begin
          for (int k = int'(m_off); k < FW; k++) begin
            e.pc = out_addr + 32'(4*k);
            e.ins = word(e.pc);
            q.push_back(e);
          end
          m_off = 0;
        end
      end
      if (acc) begin
        outstanding = 1; out_addr = m_pc; m_pc += 8;
        lat = lat_lo + int'($urandom_range(0, lat_hi - lat_lo));
      end
    end
    started = 1;
    @(negedge clk);
    check_all();
  endtask
  initial begin
    checks = 0; errors = 0; prog_end = 32'hFFFF_FFF0; lat_lo = 0; lat_hi = 0;
    reset_dut();
    repeat (12) step(1, 0, 0, 0);
    chk("s1_count", count, 8);
    chk("s1_req", req, 0);
    chk("s1_pc", ipc, 64'h0000_0004_0000_0000);
    step(1, 2, 0, 0);
    chk("s2_count", count, 6);
    chk("s2_req", req, 1);
    chk("s2_addr", addr, 32'h20);
    lat_lo = 2; lat_hi = 2;
    step(1, 2, 0, 0);
    step(1, 0, 1, 32'h104);
    for (int i = 0; i < 20 && !exp_req(); i++) step(1, 0, 0, 0);
    chk("s3_req", req, 1);
    chk("s3_addr", addr, 32'h100);
    for (int i = 0; i < 20 && q.size() == 0; i++) step(1, 0, 0, 0);
    chk("s3_count", count, 1);
    chk("s3_valid", valid, 2'b01);
    chk("s3_pc", ipc[31:0], 32'h104);
    reset_dut();
    prog_end = 32'h18; lat_lo = 0; lat_hi = 2;
    for (int i = 0; i < 60 && !ended; i++) step(1, 0, 0, 0);
    chk("s4_count", count, 6);
    chk("s4_done0", done, 0);
    for (int i = 0; i < 6; i++) step(1, 2, 0, 0);
    chk("s4_done", done, 1);
    chk("s4_req", req, 0);
    reset_dut();
    prog_end = 32'hFFFF_FFF0; lat_lo = 0; lat_hi = 0;
    for (int i = 0; i < 30 && !(q.size() == 4 && outstanding); i++) step(1, 0, 0, 0);
    step(1, 2, 1, 32'h40);
    chk("s5_count", count, 0);
`ifdef FETCH_UNIT_STATS_EN
    chk("s5_killed", killed, 1);
`endif
    lat_lo = 2; lat_hi = 2;
    for (int i = 0; i < 10 && !outstanding; i++) step(1, 0, 0, 0);
    reset_dut();
    step(1, 0, 0, 0);
    chk("s6_req", req, 1);
    chk("s6_addr", addr, 32'h0);
    lat_lo = 0; lat_hi = 3; prog_end = 32'h180;
    repeat (400)
      step($urandom_range(0, 3) != 0, 2'($urandom_range(0, 2)), $urandom_range(0, 19) == 0,
           {23'b0, 7'($urandom_range(0, 127)), 2'b00});
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
